commit_align_monitor: RTL and testbench
=======================================

# commit_align_monitor

Parametrised two-copy commit-alignment and contract-violation monitor for the simpleooo two-copy verification top. Observes the commit ports of two `cpu_ooo` copies running in lockstep. When one copy commits ahead of the other it buffers up to DEPTH early commit records instead of stalling at once, and compares records in program order. It flags programs whose committed memory reads or branch outcomes differ (`invalid_program`), and reports when each copy has drained its ROB past the first deviation.

## Interface
Parameters:
- `ADDR_W`, 4: memory address width (`MEMD_SIZE_LOG`).
- `ROB_LOG`, 3: ROB index width (`ROB_SIZE_LOG`).
- `DEPTH`, 4: early-commit record buffer depth; power of two, ≥1.
- `OBSV_MODE`, 0: 0 = commit-order observation only; 1 = also treat any `ld_addr` mismatch as a deviation (`OBSV_EVERY_ADDR`).

Ports (k ∈ {1,2}, one set per copy):
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `ck_valid`  in  1  copy k commits an instruction this cycle.
- `ck_mem_valid`  in  1  committed instruction is a memory op.
- `ck_mem_rdwt`  in  1  memory op is a read.
- `ck_mem_addr`  in  ADDR_W  memory address.
- `ck_is_br`  in  1  committed instruction is a branch.
- `ck_taken`  in  1  branch outcome.
- `ck_squash`  in  1  commit squashes the pipeline.
- `ck_rob_head`  in  ROB_LOG  ROB head index.
- `ck_rob_tail`  in  ROB_LOG  ROB tail index.
- `ck_ld_addr`  in  ADDR_W  current load address (used in OBSV_MODE 1).
- `stall_k`  out  1  gate copy k's clock.
- `lead`  out  2  0 = aligned, 1 = copy1 ahead, 2 = copy2 ahead.
- `commit_deviation`, `addr_deviation`, `invalid_program`, `finish_k`  out  1  sticky status flags.

## Operation
- Record = {mem_valid, mem_rdwt, mem_addr, is_br, taken}.
- Effective commit: `ek = ck_valid && !stall_k`.
- Records mismatch when:
  - both are memory reads and their addresses differ, or
  - both are branches and their `taken` values differ.
- Any mismatch sets `invalid_program`, which is sticky.

Behaviour by `lead`:
- `lead==0`:
  - e1 && e2: compare the two live records directly.
  - Exactly one ek: push copy k's record, set `lead<=k`, set `commit_deviation`.
- `lead==k`:
  - ek pushes copy k's record.
  - e(other) pops the FIFO head and compares it with the other copy's live record.
  - Simultaneous push and pop is legal.
  - A pop that leaves the FIFO empty with no push sets `lead<=0`.
- Stall: `stall_k = (lead==k) && full`. Combinational from registers only.
- Addr deviation: if OBSV_MODE==1 && !commit_deviation && c1_ld_addr != c2_ld_addr, set `addr_deviation`.
- Tail capture: on the first cycle either deviation flag would become set, latch `tail_1<=c1_rob_tail` and `tail_2<=c2_rob_tail`. Never recapture.
- Drain: once `dev = commit_deviation || addr_deviation` is set, set `finish_k` (sticky) when:
  - ck_valid && ck_rob_head == tail_k−1 (mod 2^ROB_LOG), or
  - ck_valid && ck_squash.

## Timing
- Reset values: all outputs 0, FIFO empty, tails 0.
- Flags register one cycle after the triggering commit.
- `stall_k` asserts in the cycle after the push that fills the FIFO. The committing copy is never stalled in the cycle of that push.
- Full: the leader is stalled, so no push is possible. A pop the same cycle deasserts `stall` next cycle.
- Empty with `lead==0` is the only aligned state. Popping while empty cannot occur.
- FIFO pointers wrap modulo DEPTH. Use an occupancy counter of width log2(DEPTH)+1.
- `finish_k` evaluation uses tails as registered. A deviation and a drain condition in the same cycle do not set finish.
- `rst` mid-operation clears FIFO, lead, tails and all flags the next edge, regardless of state.

## Structure
- Record field widths and the OBSV_MODE encodings go in `src/simpleooo/param.v`, alongside `OBSV_EVERY_ADDR`.
- Sub-module `commit_rec_fifo`: synchronous FIFO with push, pop, full, empty and head; DEPTH and width parameters.
- The monitor holds `lead`, the flags and the tails, plus the compare logic.

## Test plan
- Both copies commit reads to 3 and 3, then 5 and 6 in the same cycle → `invalid_program`=1 the next cycle; `lead` stays 0.
- c1 commits a branch taken=1 alone → `lead`=1 and `commit_deviation`=1. Two cycles later c2 commits a branch taken=0 → `invalid_program`=1 and `lead`=0.
- DEPTH=4; c1 commits 4 times while c2 is idle → `stall_1`=1 the cycle after the 4th commit. One c2 commit → `stall_1`=0 the next cycle.
- Simultaneous push and pop at occupancy 2 → occupancy stays 2; records compare in FIFO order.
- Deviation with c1_rob_tail=0 captured; later c1 commits with head=7 (ROB_LOG=3) → `finish_1`=1. A c2 squash commit → `finish_2`=1.
- OBSV_MODE=1; ld_addr 2 vs 9 → `addr_deviation`=1 with tails latched. Assert `rst` two cycles later → every output is 0.

Source files
------------

// File: rtl/commit_align_monitor_pkg.sv
// Shared types and encodings for the two-copy commit-alignment monitor.
// Record layout (MSB..LSB): {mem_valid, mem_rdwt, mem_addr, is_br, taken}.
package commit_align_monitor_pkg;

    typedef enum logic [1:0] {
        LEAD_NONE = 2'd0,
        LEAD_C1   = 2'd1,
        LEAD_C2   = 2'd2
    } lead_e;

    localparam int unsigned OBSV_COMMIT_ONLY = 0;
    localparam int unsigned OBSV_EVERY_ADDR  = 1;

    // Record bits other than the address field
    localparam int unsigned REC_CTRL_W   = 4;
    localparam int unsigned REC_TAKEN_BIT = 0;
    localparam int unsigned REC_BR_BIT    = 1;
    localparam int unsigned REC_ADDR_LSB  = 2;

endpackage

// File: rtl/commit_align_monitor_fifo.sv
// Synchronous FIFO holding early commit records from the leading copy.
// o_last flags a single remaining entry so the monitor can return to aligned.
module commit_rec_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_last
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_last    = (r_count == CNT_W'(1));
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/commit_align_monitor.sv
// Two-copy commit alignment monitor: buffers the leading copy's commits,
// compares records in program order and tracks deviation/drain status.
module commit_align_monitor
    import commit_align_monitor_pkg::*;
#(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned ROB_LOG   = 3,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned OBSV_MODE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               c1_valid,
    input  logic               c1_mem_valid,
    input  logic               c1_mem_rdwt,
    input  logic [ADDR_W-1:0]  c1_mem_addr,
    input  logic               c1_is_br,
    input  logic               c1_taken,
    input  logic               c1_squash,
    input  logic [ROB_LOG-1:0] c1_rob_head,
    input  logic [ROB_LOG-1:0] c1_rob_tail,
    input  logic [ADDR_W-1:0]  c1_ld_addr,
    input  logic               c2_valid,
    input  logic               c2_mem_valid,
    input  logic               c2_mem_rdwt,
    input  logic [ADDR_W-1:0]  c2_mem_addr,
    input  logic               c2_is_br,
    input  logic               c2_taken,
    input  logic               c2_squash,
    input  logic [ROB_LOG-1:0] c2_rob_head,
    input  logic [ROB_LOG-1:0] c2_rob_tail,
    input  logic [ADDR_W-1:0]  c2_ld_addr,
    output logic               stall_1,
    output logic               stall_2,
    output logic [1:0]         lead,
    output logic               commit_deviation,
    output logic               addr_deviation,
    output logic               invalid_program,
    output logic               finish_1,
    output logic               finish_2
);
    localparam int unsigned REC_W = ADDR_W + REC_CTRL_W;

    lead_e              r_lead;
    lead_e              w_lead_nxt;
    logic               r_cdev, r_adev, r_invalid, r_fin1, r_fin2;
    logic [ROB_LOG-1:0] r_tail_1, r_tail_2;

    logic [REC_W-1:0]   w_rec1, w_rec2, w_push_data, w_head, w_cmp_a, w_cmp_b;
    logic               w_e1, w_e2, w_push, w_pop, w_cmp_en;
    logic               w_full, w_empty, w_last;
    logic               w_set_cdev, w_set_adev, w_dev, w_capture;
    logic               w_drain1, w_drain2;

    function automatic logic rec_mismatch(input logic [REC_W-1:0] a, input logic [REC_W-1:0] b);
        logic a_rd, b_rd;
        a_rd = a[REC_W-1] && a[REC_W-2];
        b_rd = b[REC_W-1] && b[REC_W-2];
        return (a_rd && b_rd && (a[REC_ADDR_LSB +: ADDR_W] != b[REC_ADDR_LSB +: ADDR_W]))
            || (a[REC_BR_BIT] && b[REC_BR_BIT] && (a[REC_TAKEN_BIT] != b[REC_TAKEN_BIT]));
    endfunction

    assign w_rec1 = {c1_mem_valid, c1_mem_rdwt, c1_mem_addr, c1_is_br, c1_taken};
    assign w_rec2 = {c2_mem_valid, c2_mem_rdwt, c2_mem_addr, c2_is_br, c2_taken};
    assign w_e1   = c1_valid && !stall_1;
    assign w_e2   = c2_valid && !stall_2;

    commit_rec_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_push_data),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lead <= LEAD_NONE;
        end else begin
            r_lead <= w_lead_nxt;
        end
    end

    // The leader pushes, the trailer pops and compares against the FIFO head
    always_comb begin
        w_lead_nxt  = r_lead;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_push_data = w_rec1;
        w_cmp_en    = 1'b0;
        w_cmp_a     = w_rec1;
        w_cmp_b     = w_rec2;
        w_set_cdev  = 1'b0;
        unique case (r_lead)
            LEAD_NONE: begin
                if (w_e1 && w_e2) begin
                    w_cmp_en = 1'b1;
                end else if (w_e1) begin
                    w_push     = 1'b1;
                    w_lead_nxt = LEAD_C1;
                    w_set_cdev = 1'b1;
                end else if (w_e2) begin
                    w_push      = 1'b1;
                    w_push_data = w_rec2;
                    w_lead_nxt  = LEAD_C2;
                    w_set_cdev  = 1'b1;
                end
            end
            LEAD_C1: begin
                w_push   = w_e1;
                w_pop    = w_e2 && !w_empty;
                w_cmp_en = w_pop;
                w_cmp_a  = w_head;
                w_cmp_b  = w_rec2;
                if (w_pop && !w_push && w_last) begin
                    w_lead_nxt = LEAD_NONE;
                end
            end
            LEAD_C2: begin
                w_push      = w_e2;
                w_push_data = w_rec2;
                w_pop       = w_e1 && !w_empty;
                w_cmp_en    = w_pop;
                w_cmp_a     = w_rec1;
                w_cmp_b     = w_head;
                if (w_pop && !w_push && w_last) begin
                    w_lead_nxt = LEAD_NONE;
                end
            end
            default: w_lead_nxt = LEAD_NONE;
        endcase
    end

    always_comb begin
        stall_1 = (r_lead == LEAD_C1) && w_full;
        stall_2 = (r_lead == LEAD_C2) && w_full;
        lead    = r_lead;
    end

    assign w_set_adev = (OBSV_MODE == OBSV_EVERY_ADDR) && !r_cdev && (c1_ld_addr != c2_ld_addr);
    assign w_dev      = r_cdev || r_adev;
    // Registered deviation state means tails latch only on the first deviation
    assign w_capture  = (w_set_cdev || w_set_adev) && !w_dev;
    assign w_drain1   = w_dev && c1_valid && ((c1_rob_head == r_tail_1 - ROB_LOG'(1)) || c1_squash);
    assign w_drain2   = w_dev && c2_valid && ((c2_rob_head == r_tail_2 - ROB_LOG'(1)) || c2_squash);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cdev    <= 1'b0;
            r_adev    <= 1'b0;
            r_invalid <= 1'b0;
            r_fin1    <= 1'b0;
            r_fin2    <= 1'b0;
            r_tail_1  <= '0;
            r_tail_2  <= '0;
        end else begin
            if (w_cmp_en && rec_mismatch(w_cmp_a, w_cmp_b)) begin
                r_invalid <= 1'b1;
            end
            if (w_set_cdev) begin
                r_cdev <= 1'b1;
            end
            if (w_set_adev) begin
                r_adev <= 1'b1;
            end
            if (w_capture) begin
                r_tail_1 <= c1_rob_tail;
                r_tail_2 <= c2_rob_tail;
            end
            if (w_drain1) begin
                r_fin1 <= 1'b1;
            end
            if (w_drain2) begin
                r_fin2 <= 1'b1;
            end
        end
    end

    assign commit_deviation = r_cdev;
    assign addr_deviation   = r_adev;
    assign invalid_program  = r_invalid;
    assign finish_1         = r_fin1;
    assign finish_2         = r_fin2;

endmodule

// File: tb/tb_commit_align_monitor.sv
// Directed bench for commit_align_monitor (DEPTH=4, ROB_LOG=3, OBSV_MODE=1).
module tb_commit_align_monitor;
    logic       clk = 1'b0;
    logic       rst;
    logic       c1_valid, c1_mem_valid, c1_mem_rdwt, c1_is_br, c1_taken, c1_squash;
    logic [3:0] c1_mem_addr, c1_ld_addr;
    logic [2:0] c1_rob_head, c1_rob_tail;
    logic       c2_valid, c2_mem_valid, c2_mem_rdwt, c2_is_br, c2_taken, c2_squash;
    logic [3:0] c2_mem_addr, c2_ld_addr;
    logic [2:0] c2_rob_head, c2_rob_tail;
    logic       stall_1, stall_2, commit_deviation, addr_deviation, invalid_program;
    logic       finish_1, finish_2;
    logic [1:0] lead;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    commit_align_monitor #(
        .ADDR_W    (4),
        .ROB_LOG   (3),
        .DEPTH     (4),
        .OBSV_MODE (1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .c1_valid         (c1_valid),
        .c1_mem_valid     (c1_mem_valid),
        .c1_mem_rdwt      (c1_mem_rdwt),
        .c1_mem_addr      (c1_mem_addr),
        .c1_is_br         (c1_is_br),
        .c1_taken         (c1_taken),
        .c1_squash        (c1_squash),
        .c1_rob_head      (c1_rob_head),
        .c1_rob_tail      (c1_rob_tail),
        .c1_ld_addr       (c1_ld_addr),
        .c2_valid         (c2_valid),
        .c2_mem_valid     (c2_mem_valid),
        .c2_mem_rdwt      (c2_mem_rdwt),
        .c2_mem_addr      (c2_mem_addr),
        .c2_is_br         (c2_is_br),
        .c2_taken         (c2_taken),
        .c2_squash        (c2_squash),
        .c2_rob_head      (c2_rob_head),
        .c2_rob_tail      (c2_rob_tail),
        .c2_ld_addr       (c2_ld_addr),
        .stall_1          (stall_1),
        .stall_2          (stall_2),
        .lead             (lead),
        .commit_deviation (commit_deviation),
        .addr_deviation   (addr_deviation),
        .invalid_program  (invalid_program),
        .finish_1         (finish_1),
        .finish_2         (finish_2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // valid, mem_valid, mem_rdwt, addr, is_br, taken
    task automatic set_c1(input logic v, input logic mv, input logic rd, input logic [3:0] a,
                          input logic br, input logic tk);
        c1_valid = v; c1_mem_valid = mv; c1_mem_rdwt = rd; c1_mem_addr = a;
        c1_is_br = br; c1_taken = tk;
    endtask

    task automatic set_c2(input logic v, input logic mv, input logic rd, input logic [3:0] a,
                          input logic br, input logic tk);
        c2_valid = v; c2_mem_valid = mv; c2_mem_rdwt = rd; c2_mem_addr = a;
        c2_is_br = br; c2_taken = tk;
    endtask

    task automatic idle();
        set_c1(0, 0, 0, 4'd0, 0, 0);
        set_c2(0, 0, 0, 4'd0, 0, 0);
        c1_squash = 0; c2_squash = 0;
        c1_rob_head = '0; c1_rob_tail = '0; c2_rob_head = '0; c2_rob_tail = '0;
        c1_ld_addr = '0; c2_ld_addr = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        logic [9:0] outs;
        outs = {stall_1, stall_2, lead, commit_deviation, addr_deviation,
                invalid_program, finish_1, finish_2};
        check(tag, {22'd0, outs}, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        idle();
        @(negedge clk);
        do_reset();
        check_all_zero("reset_outputs");

        // Aligned commits: equal reads, then differing reads
        set_c1(1, 1, 1, 4'd3, 0, 0); set_c2(1, 1, 1, 4'd3, 0, 0); tick();
        check("aligned_eq_invalid", invalid_program, 0);
        set_c1(1, 1, 1, 4'd5, 0, 0); set_c2(1, 1, 1, 4'd6, 0, 0); tick();
        check("aligned_ne_invalid", invalid_program, 1);
        check("aligned_ne_lead", lead, 0);
        check("aligned_ne_cdev", commit_deviation, 0);

        // c1 branch ahead, c2 branch with different outcome two cycles later
        do_reset();
        set_c1(1, 0, 0, 4'd0, 1, 1); tick();
        check("c1_ahead_lead", lead, 1);
        check("c1_ahead_cdev", commit_deviation, 1);
        check("c1_ahead_stall", stall_1, 0);
        idle(); tick();
        set_c2(1, 0, 0, 4'd0, 1, 0); tick();
        check("br_pop_invalid", invalid_program, 1);
        check("br_pop_lead", lead, 0);
        check("br_pop_fin2", finish_2, 0);

        // c2 ahead with a read, c1 trails with a different address
        do_reset();
        idle(); set_c2(1, 1, 1, 4'd7, 0, 0); tick();
        check("c2_ahead_lead", lead, 2);
        check("c2_ahead_stall2", stall_2, 0);
        idle(); set_c1(1, 1, 1, 4'd8, 0, 0); tick();
        check("c2_pop_invalid", invalid_program, 1);
        check("c2_pop_lead", lead, 0);

        // Fill FIFO to DEPTH, stall, then drain in order
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            idle(); set_c1(1, 1, 1, 4'(i), 0, 0); tick();
            check("fill_stall1", stall_1, (i == 4) ? 1 : 0);
        end
        check("fill_lead", lead, 1);
        set_c1(1, 1, 1, 4'd9, 0, 0); set_c2(1, 1, 1, 4'd1, 0, 0); tick();
        check("unstall_stall1", stall_1, 0);
        check("unstall_invalid", invalid_program, 0);
        check("unstall_stall2", stall_2, 0);
        for (int i = 2; i <= 4; i++) begin
            idle(); set_c2(1, 1, 1, 4'(i), 0, 0); tick();
        end
        check("drain_lead", lead, 0);
        check("drain_invalid", invalid_program, 0);

        // Simultaneous push and pop at occupancy 2
        do_reset();
        idle(); set_c1(1, 1, 1, 4'd1, 0, 0); tick();
        idle(); set_c1(1, 1, 1, 4'd2, 0, 0); tick();
        set_c1(1, 1, 1, 4'd3, 0, 0); set_c2(1, 1, 1, 4'd1, 0, 0); tick();
        check("pushpop_invalid", invalid_program, 0);
        check("pushpop_lead", lead, 1);
        idle(); set_c1(1, 1, 1, 4'd4, 0, 0); tick();
        check("pushpop_occ3_stall", stall_1, 0);
        idle(); set_c1(1, 1, 1, 4'd5, 0, 0); tick();
        check("pushpop_occ4_stall", stall_1, 1);
        for (int i = 2; i <= 5; i++) begin
            idle(); set_c2(1, 1, 1, 4'(i), 0, 0); tick();
            check("order_invalid", invalid_program, 0);
        end
        check("order_lead", lead, 0);

        // Tail capture and drain
        do_reset();
        idle(); c2_rob_tail = 3'd3; c1_rob_head = 3'd7;
        set_c1(1, 0, 0, 4'd0, 1, 1); tick();
        check("dev_same_cycle_fin1", finish_1, 0);
        check("dev_cdev", commit_deviation, 1);
        idle(); c1_rob_tail = 3'd5; c1_rob_head = 3'd7;
        set_c1(1, 0, 0, 4'd0, 1, 1); tick();
        check("drain_fin1", finish_1, 1);
        check("drain_fin2_pre", finish_2, 0);
        idle(); c2_rob_tail = 3'd3; c2_squash = 1'b1;
        set_c2(1, 0, 0, 4'd0, 0, 0); tick();
        check("squash_fin2", finish_2, 1);
        check("squash_invalid", invalid_program, 0);

        // Load-address deviation, drain on latched tails, then mid-run reset
        do_reset();
        idle(); c1_ld_addr = 4'd2; c2_ld_addr = 4'd9; c1_rob_tail = 3'd4; c2_rob_tail = 3'd6; tick();
        check("adev_set", addr_deviation, 1);
        check("adev_cdev", commit_deviation, 0);
        check("adev_lead", lead, 0);
        idle(); c1_rob_head = 3'd3; c2_rob_head = 3'd5;
        set_c1(1, 0, 0, 4'd0, 0, 0); set_c2(1, 0, 0, 4'd0, 0, 0); tick();
        check("adev_fin1", finish_1, 1);
        check("adev_fin2", finish_2, 1);
        idle(); set_c1(1, 0, 0, 4'd0, 0, 0); tick();
        check("pre_rst_lead", lead, 1);
        idle(); rst = 1'b1; tick(); rst = 1'b0;
        check_all_zero("midrun_reset_outputs");

        // After a commit deviation, load-address mismatch is ignored
        idle(); set_c1(1, 0, 0, 4'd0, 0, 0); tick();
        idle(); c1_ld_addr = 4'd1; c2_ld_addr = 4'd4; tick();
        check("adev_gated", addr_deviation, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
